// File: rtl/instr_mem_loader_pkg.sv
// Shared processor package: loader FSM encoding and image-length constants.
// Imported by the boot loader and anything that decodes its state.
package instr_mem_loader_pkg;

    // Image length arrives as two stream bytes, high byte first
    localparam int LEN_WIDTH = 16;
    localparam int LEN_BYTE  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_INSTR,
        S_ARG,
        S_WRITE,
        S_FIN
    } loader_state_t;

    function automatic logic len_too_big(
        input logic [LEN_WIDTH-1:0] len,
        input int                   addr_width
    );
        return 32'(len) > (32'd1 << addr_width);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed {instr, arg} byte image into instruction memory
// while holding the CPU fetch path in reset.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         START,
    input  logic [DATA_WIDTH-1:0]        IN_DATA,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic                         MEM_WE,
    output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
    output logic [INSTRUCTION_WIDTH-1:0] MEM_DATA,
    output logic                         CPU_HOLD,
    output logic                         DONE,
    output logic                         ERR
);

    loader_state_t state;
    loader_state_t state_next;

    logic [LEN_BYTE-1:0]   len_hi;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  len_word;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] arg;
    logic                  err_q;
    logic                  err_set;
    logic                  accept;

    assign accept    = IN_VALID && IN_READY;
    assign len_word  = {len_hi, IN_DATA[LEN_BYTE-1:0]};
    assign count_inc = count + 1'b1;

    // Counter is one bit wider than the address so a full image ends without wrap
    assign MEM_ADDR = count[ADDR_WIDTH-1:0];
    assign MEM_DATA = {instr, arg};
    assign ERR      = err_q;

    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        MEM_WE     = 1'b0;
        DONE       = 1'b0;
        err_set    = 1'b0;
        CPU_HOLD   = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    if (len_word == '0) begin
                        state_next = S_FIN;
                    end else if (len_too_big(len_word, ADDR_WIDTH)) begin
                        err_set    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_INSTR;
                    end
                end
            end
            S_INSTR: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_next = S_ARG;
                end
            end
            S_ARG: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                MEM_WE = 1'b1;
                if (LEN_WIDTH'(count_inc) == len) begin
                    state_next = S_FIN;
                end else begin
                    state_next = S_INSTR;
                end
            end
            S_FIN: begin
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi <= '0;
            len    <= '0;
        end else if (state == S_LEN_HI && accept) begin
            len_hi <= IN_DATA[LEN_BYTE-1:0];
        end else if (state == S_LEN_LO && accept) begin
            len <= len_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (state == S_IDLE && START) begin
            count <= '0;
        end else if (state == S_WRITE) begin
            count <= count_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
            arg   <= '0;
        end else if (state == S_INSTR && accept) begin
            instr <= IN_DATA;
        end else if (state == S_ARG && accept) begin
            arg <= IN_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: captures memory writes and pulses
// and compares them against hand-computed images.
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        START;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic        MEM_WE;
    logic [11:0] MEM_ADDR;
    logic [15:0] MEM_DATA;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    int pass_cnt = 0;
    int total    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [11:0] wr_addr[$];
    logic [15:0] wr_data[$];

    instr_mem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .START    (START),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .CPU_HOLD (CPU_HOLD),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (MEM_WE === 1'b1) begin
            wr_addr.push_back(MEM_ADDR);
            wr_data.push_back(MEM_DATA);
        end
        if (DONE === 1'b1) done_cnt++;
        if (ERR === 1'b1) err_cnt++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
    endtask

    // Present one byte and return on the negedge after it is accepted
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        n = 0;
        forever begin
            rdy = IN_READY;
            @(negedge clk);
            if (rdy === 1'b1) break;
            n++;
            if (n > 100) begin
                total++;
                $display("FAIL send_timeout byte=%02h ready never seen", b);
                break;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (IN_READY !== 1'b0) $display("FAIL rst_ready got=%b exp=0", IN_READY); else pass_cnt++;
        total++; if (MEM_WE !== 1'b0) $display("FAIL rst_we got=%b exp=0", MEM_WE); else pass_cnt++;
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL rst_hold got=%b exp=0", CPU_HOLD); else pass_cnt++;
        total++; if (DONE !== 1'b0) $display("FAIL rst_done got=%b exp=0", DONE); else pass_cnt++;
        total++; if (ERR !== 1'b0) $display("FAIL rst_err got=%b exp=0", ERR); else pass_cnt++;
        total++; if (MEM_ADDR !== 12'h000) $display("FAIL rst_addr got=%h exp=000", MEM_ADDR); else pass_cnt++;
        total++; if (MEM_DATA !== 16'h0000) $display("FAIL rst_data got=%h exp=0000", MEM_DATA); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [15:0] exp_d[3] = '{16'h10AA, 16'h11BB, 16'h12CC};
        int bad;
        clear_log();
        pulse_start();
        total++; if (CPU_HOLD !== 1'b1) $display("FAIL basic_hold_on got=%b exp=1", CPU_HOLD); else pass_cnt++;
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h10); send_byte(8'hAA);
        send_byte(8'h11); send_byte(8'hBB);
        send_byte(8'h12); send_byte(8'hCC);
        total++; if (MEM_WE !== 1'b1) $display("FAIL basic_we got=%b exp=1", MEM_WE); else pass_cnt++;
        total++; if (MEM_ADDR !== 12'd2) $display("FAIL basic_addr got=%h exp=002", MEM_ADDR); else pass_cnt++;
        total++; if (MEM_DATA !== 16'h12CC) $display("FAIL basic_data got=%h exp=12cc", MEM_DATA); else pass_cnt++;
        @(negedge clk);
        total++; if (DONE !== 1'b1) $display("FAIL basic_done got=%b exp=1", DONE); else pass_cnt++;
        total++; if (CPU_HOLD !== 1'b1) $display("FAIL basic_hold_fin got=%b exp=1", CPU_HOLD); else pass_cnt++;
        @(negedge clk);
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL basic_hold_off got=%b exp=0", CPU_HOLD); else pass_cnt++;
        total++; if (DONE !== 1'b0) $display("FAIL basic_done_off got=%b exp=0", DONE); else pass_cnt++;
        total++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
        total++; if (wr_addr.size() !== 3) $display("FAIL basic_wr_cnt got=%0d exp=3", wr_addr.size()); else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (k >= wr_addr.size()) bad++;
            else if (wr_addr[k] !== 12'(k) || wr_data[k] !== exp_d[k]) bad++;
        end
        total++; if (bad !== 0) $display("FAIL basic_image got=%0d bad words exp=0", bad); else pass_cnt++;
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        total++; if (DONE !== 1'b1) $display("FAIL zero_done got=%b exp=1", DONE); else pass_cnt++;
        @(negedge clk);
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL zero_idle_hold got=%b exp=0", CPU_HOLD); else pass_cnt++;
        total++; if (wr_addr.size() !== 0) $display("FAIL zero_wr_cnt got=%0d exp=0", wr_addr.size()); else pass_cnt++;
        total++; if (done_cnt !== 1) $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_len_err();
        clear_log();
        pulse_start();
        send_byte(8'h10); send_byte(8'h01);
        total++; if (ERR !== 1'b1) $display("FAIL err_pulse got=%b exp=1", ERR); else pass_cnt++;
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL err_hold got=%b exp=0", CPU_HOLD); else pass_cnt++;
        total++; if (IN_READY !== 1'b0) $display("FAIL err_ready got=%b exp=0", IN_READY); else pass_cnt++;
        @(negedge clk);
        total++; if (ERR !== 1'b0) $display("FAIL err_pulse_end got=%b exp=0", ERR); else pass_cnt++;
        total++; if (err_cnt !== 1) $display("FAIL err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
        total++; if (done_cnt !== 0) $display("FAIL err_no_done got=%0d exp=0", done_cnt); else pass_cnt++;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAB); send_byte(8'hCD);
        @(negedge clk);
        total++; if (DONE !== 1'b1) $display("FAIL err_reload_done got=%b exp=1", DONE); else pass_cnt++;
        @(negedge clk);
        total++; if (wr_addr.size() !== 1) $display("FAIL err_reload_cnt got=%0d exp=1", wr_addr.size()); else pass_cnt++;
        total++; if (wr_data.size() < 1 || wr_data[0] !== 16'hABCD || wr_addr[0] !== 12'h000)
            $display("FAIL err_reload_word got=%0d entries exp=abcd@000", wr_data.size());
        else pass_cnt++;
    endtask

    task automatic test_full_load();
        logic [11:0] idx;
        logic [15:0] exp;
        int bad;
        int waited;
        clear_log();
        pulse_start();
        send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 4096; i++) begin
            idx = 12'(i);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(idx[7:0]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(idx[11:4] ^ 8'hC3);
        end
        waited = 0;
        while (DONE !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        total++; if (DONE !== 1'b1) $display("FAIL full_done got=%b exp=1", DONE); else pass_cnt++;
        @(negedge clk);
        total++; if (done_cnt !== 1) $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
        total++; if (wr_addr.size() !== 4096) $display("FAIL full_wr_cnt got=%0d exp=4096", wr_addr.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            idx = 12'(i);
            exp = {idx[7:0], idx[11:4] ^ 8'hC3};
            if (i >= wr_addr.size()) bad++;
            else if (wr_addr[i] !== idx || wr_data[i] !== exp) bad++;
        end
        total++; if (bad !== 0) $display("FAIL full_image got=%0d bad words exp=0", bad); else pass_cnt++;
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL full_hold_off got=%b exp=0", CPU_HOLD); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        reset = 1'b1;
        #1;
        total++; if (MEM_WE !== 1'b0) $display("FAIL abort_we got=%b exp=0", MEM_WE); else pass_cnt++;
        total++; if (CPU_HOLD !== 1'b0) $display("FAIL abort_hold got=%b exp=0", CPU_HOLD); else pass_cnt++;
        total++; if (MEM_ADDR !== 12'h000) $display("FAIL abort_addr got=%h exp=000", MEM_ADDR); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (IN_READY !== 1'b0) $display("FAIL abort_idle got=%b exp=0", IN_READY); else pass_cnt++;
        total++; if (done_cnt !== 0 || err_cnt !== 0)
            $display("FAIL abort_pulses got=done%0d/err%0d exp=0/0", done_cnt, err_cnt);
        else pass_cnt++;
        total++; if (wr_data.size() !== 1 || wr_data[0] !== 16'h0102)
            $display("FAIL abort_written got=%0d entries exp=1 (0102@000)", wr_data.size());
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        START = 1'b1;
        send_byte(8'h21);
        START = 1'b0;
        send_byte(8'h22);
        send_byte(8'h31); send_byte(8'h32);
        total++; if (MEM_ADDR !== 12'd1) $display("FAIL ign_addr got=%h exp=001", MEM_ADDR); else pass_cnt++;
        @(negedge clk);
        total++; if (DONE !== 1'b1) $display("FAIL ign_done got=%b exp=1", DONE); else pass_cnt++;
        @(negedge clk);
        total++; if (wr_data.size() !== 2 || wr_data[0] !== 16'h2122 || wr_data[1] !== 16'h3132
                     || wr_addr[0] !== 12'd0 || wr_addr[1] !== 12'd1)
            $display("FAIL ign_image got=%0d entries exp=2122@0,3132@1", wr_data.size());
        else pass_cnt++;
        total++; if (done_cnt !== 1) $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); else pass_cnt++;
    endtask

    initial begin
        reset    = 1'b0;
        START    = 1'b0;
        IN_DATA  = 8'h00;
        IN_VALID = 1'b0;
        #1;
        test_reset();
        test_basic_load();
        test_zero_len();
        test_len_err();
        test_start_ignored();
        test_reset_abort();
        test_full_load();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
